// File: rtl/blackjack_pkg.sv
// Shared constants, FSM encoding and card-value helper for the BlackJack datapath.
package blackjack_pkg;

  localparam int DECK_SIZE = 52;
  localparam int SUITS     = 4;
  localparam int RANKS     = 13;

  // Dealer FSM encoding
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_SAMPLE     = 3'd1;
  localparam logic [2:0] ST_PROBE      = 3'd2;
  localparam logic [2:0] ST_TIMER_CLR  = 3'd3;
  localparam logic [2:0] ST_TIMER_WAIT = 3'd4;

  // BlackJack value of a rank: face cards count as ten, ace counts as one.
  function automatic logic [3:0] rank_to_points(input logic [3:0] rank);
    return (rank > 4'd10) ? 4'd10 : rank;
  endfunction

endpackage

// File: rtl/deck_tracker.sv
// Tracks which of the 52 cards have been dealt and how many remain.
// Clear takes priority over mark; the empty flag is registered with the count.
module deck_tracker
  import blackjack_pkg::*;
(
  input  logic       clk_50M,
  input  logic       i_Reset_n,
  input  logic       i_Clear,
  input  logic       i_Mark,
  input  logic [5:0] i_Mark_Idx,
  input  logic [5:0] i_Query_Idx,
  output logic       o_Used,
  output logic [5:0] o_Cards_Left,
  output logic       o_Empty
);

  logic [DECK_SIZE-1:0] used_q, used_d;
  logic [5:0]           left_q, left_d;
  logic                 empty_q, empty_d;

  // Next-state for the used map and the remaining-card count
  always_comb begin
    used_d  = used_q;
    left_d  = left_q;
    empty_d = empty_q;
    if (i_Clear) begin
      used_d  = '0;
      left_d  = 6'(DECK_SIZE);
      empty_d = 1'b0;
    end else if (i_Mark) begin
      used_d[i_Mark_Idx] = 1'b1;
      left_d             = left_q - 6'd1;
      empty_d            = (left_q == 6'd1);
    end
  end

  // Deck state registers, full deck on reset
  always_ff @(posedge clk_50M) begin
    if (!i_Reset_n) begin
      used_q  <= '0;
      left_q  <= 6'(DECK_SIZE);
      empty_q <= 1'b0;
    end else begin
      used_q  <= used_d;
      left_q  <= left_d;
      empty_q <= empty_d;
    end
  end

  assign o_Used       = used_q[i_Query_Idx];
  assign o_Cards_Left = left_q;
  assign o_Empty      = empty_q;

endmodule

// File: rtl/card_dealer.sv
// Deals one undealt card per request using the free-running counter as seed,
// then holds the card on display through the Counter's two-second timer.
// Handshake: i_Deal is a level sampled only in IDLE; o_Card_Valid pulses for
// one cycle when o_Card_Rank/o_Card_Points update; the timer phase pulses
// o_Timer_Zero for two cycles, then raises o_Timer_Active until i_TwoSec.
module card_dealer
  import blackjack_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int USE_HOLD = 1
) (
  input  logic             clk_50M,
  input  logic             i_Reset_n,
  input  logic [WIDTH-1:0] i_Seed,
  input  logic             i_Deal,
  input  logic             i_Shuffle,
  input  logic             i_TwoSec,
  output logic             o_Timer_Zero,
  output logic             o_Timer_Active,
  output logic [3:0]       o_Card_Rank,
  output logic [3:0]       o_Card_Points,
  output logic             o_Card_Valid,
  output logic             o_Busy,
  output logic             o_Deck_Empty,
  output logic [5:0]       o_Cards_Left
);

  logic [2:0] state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic       hold_q, hold_d;
  logic [3:0] rank_q, rank_d;
  logic [3:0] points_q, points_d;
  logic       valid_q, valid_d;
  logic       zero_q, active_q, busy_q;

  logic       deck_clear, deck_mark, deck_used, deck_empty;
  logic [5:0] seed_raw, seed_idx;

  if (WIDTH > 6) begin : g_seed_hi
    logic unused_seed_hi;
    assign unused_seed_hi = ^i_Seed[WIDTH-1:6];
  end

  // Fold the low six seed bits into the 0..51 card index range
  always_comb begin
    seed_raw = i_Seed[5:0];
    seed_idx = (seed_raw >= 6'(DECK_SIZE)) ? seed_raw - 6'(DECK_SIZE) : seed_raw;
  end

  // Dealer FSM: sample seed, linear-probe for a free card, run the display timer
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    rank_d     = rank_q;
    points_d   = points_q;
    valid_d    = 1'b0;
    deck_clear = 1'b0;
    deck_mark  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_Shuffle) begin
          deck_clear = 1'b1;
        end else if (i_Deal && !deck_empty) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        idx_d   = seed_idx;
        state_d = ST_PROBE;
      end
      ST_PROBE: begin
        if (deck_used) begin
          idx_d = (idx_q == 6'(DECK_SIZE - 1)) ? 6'd0 : idx_q + 6'd1;
        end else begin
          deck_mark = 1'b1;
          rank_d    = idx_q[5:2] + 4'd1;
          points_d  = rank_to_points(idx_q[5:2] + 4'd1);
          valid_d   = 1'b1;
          hold_d    = 1'b0;
          state_d   = (USE_HOLD != 0) ? ST_TIMER_CLR : ST_IDLE;
        end
      end
      ST_TIMER_CLR: begin
        // Two cycles of clear so a stale sticky i_TwoSec is flushed
        if (hold_q) begin
          hold_d  = 1'b0;
          state_d = ST_TIMER_WAIT;
        end else begin
          hold_d = 1'b1;
        end
      end
      ST_TIMER_WAIT: begin
        if (i_TwoSec) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; timer/busy outputs follow the next state
  always_ff @(posedge clk_50M) begin
    if (!i_Reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      hold_q   <= 1'b0;
      rank_q   <= '0;
      points_q <= '0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      rank_q   <= rank_d;
      points_q <= points_d;
      valid_q  <= valid_d;
      zero_q   <= (state_d == ST_TIMER_CLR);
      active_q <= (state_d == ST_TIMER_WAIT);
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  deck_tracker u_deck (
    .clk_50M      (clk_50M),
    .i_Reset_n    (i_Reset_n),
    .i_Clear      (deck_clear),
    .i_Mark       (deck_mark),
    .i_Mark_Idx   (idx_q),
    .i_Query_Idx  (idx_q),
    .o_Used       (deck_used),
    .o_Cards_Left (o_Cards_Left),
    .o_Empty      (deck_empty)
  );

  assign o_Deck_Empty   = deck_empty;
  assign o_Timer_Zero   = zero_q;
  assign o_Timer_Active = active_q;
  assign o_Card_Rank    = rank_q;
  assign o_Card_Points  = points_q;
  assign o_Card_Valid   = valid_q;
  assign o_Busy         = busy_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: latency, probing, wrap, timer handshake,
// empty deck, shuffle priority and mid-operation reset.
module tb_card_dealer;

  logic        clk_50M = 1'b0;
  logic        i_Reset_n;
  logic [11:0] i_Seed;
  logic        i_Deal, i_Shuffle, i_TwoSec;
  logic        o_Timer_Zero, o_Timer_Active, o_Card_Valid, o_Busy, o_Deck_Empty;
  logic [3:0]  o_Card_Rank, o_Card_Points;
  logic [5:0]  o_Cards_Left;

  int n_checks = 0;
  int n_fail   = 0;
  logic used_m [52];
  int   left_m;

  card_dealer #(.WIDTH(12), .USE_HOLD(1)) dut (
    .clk_50M        (clk_50M),
    .i_Reset_n      (i_Reset_n),
    .i_Seed         (i_Seed),
    .i_Deal         (i_Deal),
    .i_Shuffle      (i_Shuffle),
    .i_TwoSec       (i_TwoSec),
    .o_Timer_Zero   (o_Timer_Zero),
    .o_Timer_Active (o_Timer_Active),
    .o_Card_Rank    (o_Card_Rank),
    .o_Card_Points  (o_Card_Points),
    .o_Card_Valid   (o_Card_Valid),
    .o_Busy         (o_Busy),
    .o_Deck_Empty   (o_Deck_Empty),
    .o_Cards_Left   (o_Cards_Left)
  );

  // clock / reset
  always #10 clk_50M = ~clk_50M;

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 52; j++) used_m[j] = 1'b0;
    left_m = 52;
  endtask

  task automatic model_mark(input int idx);
    used_m[idx] = 1'b1;
    left_m--;
  endtask

  // Drive one deal request; returns edges from request to Valid (0 on timeout)
  task automatic do_deal(input logic [11:0] seed, output int lat);
    i_Seed = seed;
    i_Deal = 1'b1;
    lat    = 0;
    for (int n = 1; n <= 80; n++) begin
      tick();
      if (n == 1) i_Deal = 1'b0;
      if (o_Card_Valid) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) check("deal_valid_timeout", {31'd0, o_Card_Valid}, 32'd1);
  endtask

  // Assert the two-second flag until the dealer returns to IDLE
  task automatic release_hold();
    i_TwoSec = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (!o_Busy) break;
    end
    i_TwoSec = 1'b0;
    check("hold_exit_busy", {31'd0, o_Busy}, 32'd0);
    check("hold_exit_active", {31'd0, o_Timer_Active}, 32'd0);
  endtask

  initial begin
    int lat;
    int f;
    i_Reset_n = 1'b0; i_Seed = '0; i_Deal = 1'b0; i_Shuffle = 1'b0; i_TwoSec = 1'b0;
    model_reset();
    tick(); tick();
    check("rst_left", o_Cards_Left, 52);
    check("rst_busy", o_Busy, 0);
    check("rst_valid", o_Card_Valid, 0);
    check("rst_rank", o_Card_Rank, 0);
    check("rst_empty", o_Deck_Empty, 0);
    i_Reset_n = 1'b1;
    tick();

    // 1: seed 0 -> idx 0, three-edge latency, two-cycle timer clear
    do_deal(12'd0, lat); model_mark(0);
    check("t1_lat", lat, 3);
    check("t1_rank", o_Card_Rank, 1);
    check("t1_points", o_Card_Points, 1);
    check("t1_left", o_Cards_Left, 51);
    check("t1_busy", o_Busy, 1);
    check("t1_zero_c1", o_Timer_Zero, 1);
    check("t1_active_c1", o_Timer_Active, 0);
    tick();
    check("t1_valid_pulse", o_Card_Valid, 0);
    check("t1_zero_c2", o_Timer_Zero, 1);
    tick();
    check("t1_zero_c3", o_Timer_Zero, 0);
    check("t1_active_c3", o_Timer_Active, 1);
    release_hold();

    // 2: seed 55 folds to idx 3; seed 3 then probes to idx 4
    do_deal(12'd55, lat); model_mark(3);
    check("t2a_lat", lat, 3);
    check("t2a_rank", o_Card_Rank, 1);
    release_hold();
    do_deal(12'd3, lat); model_mark(4);
    check("t2b_lat", lat, 4);
    check("t2b_rank", o_Card_Rank, 2);
    check("t2b_points", o_Card_Points, 2);
    tick(); tick();
    i_Deal = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("t2_wait_no_valid", o_Card_Valid, 0);
      check("t2_wait_active", o_Timer_Active, 1);
    end
    i_Deal = 1'b0;
    release_hold();

    // 3: idx 51 is a king; repeat wraps past 51 and used 0 to idx 1
    do_deal(12'd51, lat); model_mark(51);
    check("t3a_rank", o_Card_Rank, 13);
    check("t3a_points", o_Card_Points, 10);
    release_hold();
    do_deal(12'd51, lat); model_mark(1);
    check("t3b_lat", lat, 5);
    check("t3b_rank", o_Card_Rank, 1);
    release_hold();

    // 4: jack, with i_TwoSec held high through the timer clear
    do_deal(12'd40, lat); model_mark(40);
    i_TwoSec = 1'b1;
    check("t4_rank", o_Card_Rank, 11);
    check("t4_points", o_Card_Points, 10);
    tick();
    check("t4_clr_zero", o_Timer_Zero, 1);
    check("t4_clr_busy", o_Busy, 1);
    tick();
    check("t4_wait_active", o_Timer_Active, 1);
    check("t4_wait_zero", o_Timer_Zero, 0);
    tick();
    check("t4_exit_active", o_Timer_Active, 0);
    check("t4_exit_busy", o_Busy, 0);
    i_TwoSec = 1'b0;
    check("t4_left", o_Cards_Left, 46);

    // 5: deal the rest of the deck from seed 0, lowest free index each time
    while (left_m > 0) begin
      f = 0;
      for (int j = 51; j >= 0; j--) if (!used_m[j]) f = j;
      do_deal(12'd0, lat); model_mark(f);
      check("t5_lat", lat, 3 + f);
      check("t5_rank", o_Card_Rank, f / 4 + 1);
      check("t5_left", o_Cards_Left, left_m);
      release_hold();
    end
    check("t5_empty", o_Deck_Empty, 1);
    check("t5_left_zero", o_Cards_Left, 0);
    i_Deal = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("t5_empty_no_valid", o_Card_Valid, 0);
      check("t5_empty_idle", o_Busy, 0);
    end
    i_Shuffle = 1'b1;
    tick();
    i_Shuffle = 1'b0; i_Deal = 1'b0;
    model_reset();
    check("t5_shuffle_left", o_Cards_Left, 52);
    check("t5_shuffle_empty", o_Deck_Empty, 0);
    tick();
    check("t5_shuffle_no_valid", o_Card_Valid, 0);
    check("t5_shuffle_idle", o_Busy, 0);

    // 6: reset during TIMER_WAIT, then during PROBE
    do_deal(12'd7, lat);
    check("t6_rank", o_Card_Rank, 2);
    check("t6_left", o_Cards_Left, 51);
    tick(); tick();
    check("t6_in_wait", o_Timer_Active, 1);
    i_Reset_n = 1'b0;
    tick();
    i_Reset_n = 1'b1;
    check("t6w_active", o_Timer_Active, 0);
    check("t6w_busy", o_Busy, 0);
    check("t6w_rank", o_Card_Rank, 0);
    check("t6w_points", o_Card_Points, 0);
    check("t6w_left", o_Cards_Left, 52);
    i_Seed = 12'd9; i_Deal = 1'b1;
    tick();
    i_Deal = 1'b0;
    tick();
    check("t6p_busy_before", o_Busy, 1);
    i_Reset_n = 1'b0;
    tick();
    i_Reset_n = 1'b1;
    check("t6p_valid", o_Card_Valid, 0);
    check("t6p_busy", o_Busy, 0);
    check("t6p_zero", o_Timer_Zero, 0);
    check("t6p_left", o_Cards_Left, 52);
    tick();
    check("t6p_idle_after", o_Busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
